// File: rtl/pipe_stage_latch.sv
// Generic inter-stage pipeline register for IR, PC, control word, data channels and branch-predict bit.
// It provides valid/ready handshaking, squash, NOP bubbles and a saturating stall counter. Define SKID_BUFFER_EN to add a registered-ready skid entry.
module pipe_stage_latch #(
   parameter int                  IR_WIDTH   = 16,
   parameter int                  PC_WIDTH   = 16,
   parameter int                  DATA_WIDTH = 16,
   parameter int                  NUM_DATA   = 2,
   parameter int                  CW_WIDTH   = 8,
   parameter logic [CW_WIDTH-1:0] NOP_CW     = '0,
   parameter int                  CNT_WIDTH  = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [IR_WIDTH-1:0]            in_ir,
   input  logic [PC_WIDTH-1:0]            in_pc,
   input  logic [NUM_DATA*DATA_WIDTH-1:0] in_data,
   input  logic [CW_WIDTH-1:0]            in_cw,
   input  logic                           in_bp,
   input  logic                           squash,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [IR_WIDTH-1:0]            out_ir,
   output logic [PC_WIDTH-1:0]            out_pc,
   output logic [NUM_DATA*DATA_WIDTH-1:0] out_data,
   output logic [CW_WIDTH-1:0]            out_cw,
   output logic                           out_bp,
   output logic [CNT_WIDTH-1:0]           stall_count
);

   localparam int DW_ALL = NUM_DATA * DATA_WIDTH;
   localparam int PW     = IR_WIDTH + PC_WIDTH + DW_ALL + CW_WIDTH + 1;
   localparam logic [PW-1:0] HEAD_RST = {{(PW-CW_WIDTH-1){1'b0}}, NOP_CW, 1'b0};

   // Entry layout, MSB first: {ir, pc, data, cw, bp}
   logic [PW-1:0]        head_q, head_d;
   logic                 head_valid_q, head_valid_d;
   logic [CNT_WIDTH-1:0] stall_q, stall_d;
   logic [PW-1:0]        in_payload;
   logic                 accept;
   logic                 drain;

   assign in_payload = {in_ir, in_pc, in_data, in_cw, in_bp & in_valid};

`ifdef SKID_BUFFER_EN
   logic [PW-1:0] skid_q, skid_d;
   logic          skid_valid_q, skid_valid_d;

   // Ready depends only on the registered skid state, so out_ready has no combinational path to in_ready.
   assign in_ready = !skid_valid_q;
`else
   assign in_ready = !head_valid_q | out_ready;
`endif

   assign accept = in_valid & in_ready & ~squash;
   assign drain  = head_valid_q & out_ready;

   always_comb begin
      head_d       = head_q;
      head_valid_d = head_valid_q;
`ifdef SKID_BUFFER_EN
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (squash) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!head_valid_q || drain) begin
         if (skid_valid_q) begin
            head_d       = skid_q;
            head_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            head_d       = in_payload;
            head_valid_d = 1'b1;
         end else begin
            head_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = in_payload;
         skid_valid_d = 1'b1;
      end
`else
      if (squash) begin
         head_valid_d = 1'b0;
      end else begin
         if (drain) begin
            head_valid_d = 1'b0;
         end
         if (accept) begin
            head_d       = in_payload;
            head_valid_d = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      stall_d = stall_q;
      if (head_valid_q && !out_ready && !squash && !(&stall_q)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q       <= HEAD_RST;
         head_valid_q <= 1'b0;
         stall_q      <= '0;
      end else begin
         head_q       <= head_d;
         head_valid_q <= head_valid_d;
         stall_q      <= stall_d;
      end
   end

`ifdef SKID_BUFFER_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_q       <= HEAD_RST;
         skid_valid_q <= 1'b0;
      end else begin
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end
`endif

   // PC and data keep their last value during a bubble. IR, CW and BP switch to the NOP encoding.
   assign out_valid   = head_valid_q;
   assign out_ir      = head_valid_q ? head_q[PW-1 -: IR_WIDTH] : '0;
   assign out_pc      = head_q[CW_WIDTH+1+DW_ALL +: PC_WIDTH];
   assign out_data    = head_q[CW_WIDTH+1 +: DW_ALL];
   assign out_cw      = head_valid_q ? head_q[1 +: CW_WIDTH] : NOP_CW;
   assign out_bp      = head_valid_q & head_q[0];
   assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Randomised and directed bench for pipe_stage_latch, checked against a queue-based reference model.
// It covers both builds (SKID_BUFFER_EN defined or not). The counter is kept narrow so saturation is reachable.
module tb_pipe_stage_latch;
   localparam int               CNTW    = 4;
   localparam int               CNT_MAX = (1 << CNTW) - 1;
   localparam logic [7:0]       NOP     = 8'hA5;
`ifdef SKID_BUFFER_EN
   localparam int               CAP     = 2;
`else
   localparam int               CAP     = 1;
`endif

   typedef struct packed {
      logic [15:0] ir;
      logic [15:0] pc;
      logic [31:0] data;
      logic [7:0]  cw;
      logic        bp;
   } entry_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0, in_ready;
   logic [15:0]     in_ir = '0, in_pc = '0;
   logic [31:0]     in_data = '0;
   logic [7:0]      in_cw = '0;
   logic            in_bp = 1'b0, squash = 1'b0;
   logic            out_valid, out_ready = 1'b0;
   logic [15:0]     out_ir, out_pc;
   logic [31:0]     out_data;
   logic [7:0]      out_cw;
   logic            out_bp;
   logic [CNTW-1:0] stall_count;

   entry_t q[$];
   entry_t last;
   int     exp_stall;
   int     n_checks = 0;
   int     n_errors = 0;

   pipe_stage_latch #(
      .IR_WIDTH(16), .PC_WIDTH(16), .DATA_WIDTH(16), .NUM_DATA(2),
      .CW_WIDTH(8), .NOP_CW(NOP), .CNT_WIDTH(CNTW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ir(in_ir), .in_pc(in_pc), .in_data(in_data), .in_cw(in_cw), .in_bp(in_bp),
      .squash(squash),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ir(out_ir), .out_pc(out_pc), .out_data(out_data), .out_cw(out_cw), .out_bp(out_bp),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic entry_t rand_entry();
      entry_t e;
      e.ir   = 16'($urandom);
      e.pc   = 16'($urandom);
      e.data = $urandom;
      e.cw   = 8'($urandom);
      e.bp   = 1'($urandom);
      return e;
   endfunction

   function automatic entry_t mk(input logic [15:0] ir, input logic bp);
      entry_t e;
      e      = rand_entry();
      e.ir   = ir;
      e.pc   = ir + 16'h0100;
      e.bp   = bp;
      return e;
   endfunction

   task automatic check_outputs();
      entry_t h;
      logic   v;
      v = (q.size() > 0);
      h = v ? q[0] : last;
      check_eq("out_valid", 64'(out_valid), 64'(v));
      check_eq("out_ir", 64'(out_ir), v ? 64'(h.ir) : 64'd0);
      check_eq("out_pc", 64'(out_pc), 64'(h.pc));
      check_eq("out_data", 64'(out_data), 64'(h.data));
      check_eq("out_cw", 64'(out_cw), v ? 64'(h.cw) : 64'(NOP));
      check_eq("out_bp", 64'(out_bp), v ? 64'(h.bp) : 64'd0);
      check_eq("stall_count", 64'(stall_count), 64'(exp_stall));
   endtask

   // Drive one cycle of stimulus, compare the outputs before the edge, then advance the model.
   task automatic step(input logic v, input entry_t e, input logic ordy, input logic sq);
      logic exp_rdy;
      @(negedge clk);
      in_valid  = v;
      in_ir     = e.ir;
      in_pc     = e.pc;
      in_data   = e.data;
      in_cw     = e.cw;
      in_bp     = e.bp;
      out_ready = ordy;
      squash    = sq;
      #1;
      if (CAP == 2) exp_rdy = (q.size() < 2);
      else          exp_rdy = (q.size() == 0) || ordy;
      check_outputs();
      check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
      @(posedge clk);
      if (sq) begin
         q.delete();
      end else begin
         if (q.size() > 0 && !ordy && exp_stall < CNT_MAX) exp_stall++;
         if (q.size() > 0 && ordy) void'(q.pop_front());
         if (v && exp_rdy) q.push_back(e);
      end
      if (q.size() > 0) last = q[0];
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_cw", 64'(out_cw), 64'(NOP));
      check_eq("rst_out_ir", 64'(out_ir), 64'd0);
      check_eq("rst_out_bp", 64'(out_bp), 64'd0);
      check_eq("rst_stall", 64'(stall_count), 64'd0);
      q.delete();
      exp_stall = 0;
      last      = '0;
      in_valid  = 1'b0;
      squash    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      exp_stall = 0;
      last      = '0;
      do_reset();

      // Single transfer with latency 1.
      step(1'b1, '{ir:16'h1234, pc:16'h0040, data:32'h0, cw:8'h11, bp:1'b0}, 1'b1, 1'b0);
      #1;
      check_eq("t2_valid", 64'(out_valid), 64'd1);
      check_eq("t2_ir", 64'(out_ir), 64'h1234);
      check_eq("t2_pc", 64'(out_pc), 64'h0040);
      step(1'b0, rand_entry(), 1'b1, 1'b0);

      // Back-to-back stream drains in order, one per cycle.
      for (int i = 1; i <= 8; i++) step(1'b1, mk(16'(i), 1'(i)), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, rand_entry(), 1'b1, 1'b0);

      // Hold the head for 5 cycles while more work is offered.
      do_reset();
      step(1'b1, mk(16'h00AA, 1'b1), 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, mk(16'h00BB, 1'b0), 1'b0, 1'b0);
      #1;
      check_eq("t4_stall", 64'(stall_count), 64'd5);
      check_eq("t4_ir", 64'(out_ir), 64'h00AA);
      check_eq("t4_in_ready", 64'(in_ready), 64'd0);

      // Reset while the head is valid and the counter is non-zero.
      do_reset();

      // Squash a full stage together with an incoming instruction.
      step(1'b1, mk(16'h00A1, 1'b1), 1'b1, 1'b0);
      step(1'b1, mk(16'h00B2, 1'b1), 1'b0, 1'b0);
      step(1'b1, mk(16'h00EE, 1'b1), 1'b0, 1'b1);
      #1;
      check_eq("t5_valid", 64'(out_valid), 64'd0);
      check_eq("t5_ir", 64'(out_ir), 64'd0);
      check_eq("t5_bp", 64'(out_bp), 64'd0);
      check_eq("t5_cw", 64'(out_cw), 64'(NOP));
      for (int i = 0; i < 3; i++) step(1'b0, rand_entry(), 1'b1, 1'b0);

      // The stall counter saturates instead of wrapping.
      do_reset();
      step(1'b1, mk(16'h0077, 1'b0), 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, rand_entry(), 1'b0, 1'b0);
      #1;
      check_eq("t6_stall_sat", 64'(stall_count), 64'hF);
      step(1'b0, rand_entry(), 1'b1, 1'b0);

      // Random traffic with occasional squashes and resets mid-stream.
      for (int blk = 0; blk < 4; blk++) begin
         do_reset();
         for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rand_entry(),
                 (blk[0] ? $urandom_range(0, 1) : $urandom_range(0, 3)) != 0,
                 $urandom_range(0, 31) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
